// File: rtl/cbus_width_converter_n.sv
// 32-bit CBUS slave to DW-wide memory port: posts collected write beats as one wide write and
// serves read beats from a tagged line buffer. Define CBUS_WC_RD_CACHE_EN to let beat 0 hit too.
module cbus_width_converter_n #(
    parameter int DW     = 96,
    parameter int AW     = 32,
    parameter int BEATS  = 3,
    parameter int BEAT_W = 2
) (
    input  logic                 clk,
    input  logic                 sreset_n,
    input  logic                 cbus_req,
    input  logic                 cbus_cmd,
    input  logic [AW+BEAT_W-1:0] cbus_addr,
    input  logic [31:0]          cbus_wrdata,
    output logic [31:0]          cbus_rddata,
    output logic                 cbus_waccept,
    output logic                 cbus_rresp,
    output logic                 mem_req,
    output logic                 mem_cmd,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wrdata,
    input  logic [DW-1:0]        mem_rd_data,
    input  logic                 mem_waccept,
    input  logic                 mem_rresp,
    output logic                 wr_seq_err
);
    localparam int LAST  = BEATS - 1;
    localparam int TOP_W = DW - 32 * LAST;

`ifdef CBUS_WC_RD_CACHE_EN
    localparam bit BEAT0_HITS = 1'b1;
`else
    localparam bit BEAT0_HITS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_CAPT} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       slots_q, slots_d;
    logic [DW-1:0]       line_buf_q, line_buf_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       tag_q, tag_d;
    logic                tag_valid_q, tag_valid_d;
    logic [BEAT_W-1:0]   wr_exp_q, wr_exp_d;
    logic                seq_err_q, seq_err_d;
    logic                fresh_q, fresh_d;
    logic                live_q;

    logic [AW-1:0]       req_line;
    logic [BEAT_W-1:0]   req_beat;
    logic                beat_ok;
    logic                is_last;
    logic                tag_hit;
    logic                rd_hit;
    logic [32*BEATS-1:0] buf_ext;
    logic [31:0]         beat_data;

    assign req_line = cbus_addr[AW+BEAT_W-1:BEAT_W];
    assign req_beat = cbus_addr[BEAT_W-1:0];
    assign beat_ok  = int'(req_beat) < BEATS;
    assign is_last  = (req_beat == BEAT_W'(LAST));
    assign tag_hit  = tag_valid_q && (tag_q == req_line);
    // fresh_q lets the request that caused a fill complete on beat 0 even in legacy mode
    assign rd_hit   = tag_hit && ((req_beat != '0) || fresh_q || BEAT0_HITS);

    assign mem_addr   = addr_q;
    assign mem_wrdata = slots_q;
    assign wr_seq_err = seq_err_q;

    always_comb begin
        buf_ext           = '0;
        buf_ext[DW-1:0]   = line_buf_q;
        beat_data         = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (req_beat == BEAT_W'(i)) begin
                beat_data = buf_ext[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        slots_d      = slots_q;
        line_buf_d   = line_buf_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        wr_exp_d     = wr_exp_q;
        seq_err_d    = 1'b0;
        fresh_d      = 1'b0;
        cbus_waccept = 1'b0;
        cbus_rresp   = 1'b0;
        cbus_rddata  = '0;
        mem_req      = 1'b0;
        mem_cmd      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cbus_req && live_q) begin
                    if (!cbus_cmd) begin
                        cbus_waccept = 1'b1;
                        if (!beat_ok) begin
                            seq_err_d = 1'b1;
                        end else begin
                            seq_err_d = (req_beat != wr_exp_q);
                            if (is_last) begin
                                slots_d[DW-1:32*LAST] = cbus_wrdata[TOP_W-1:0];
                                addr_d   = req_line;
                                wr_exp_d = '0;
                                state_d  = WR_ISSUE;
                                if (tag_q == req_line) begin
                                    tag_valid_d = 1'b0;
                                end
                            end else begin
                                for (int i = 0; i < LAST; i++) begin
                                    if (req_beat == BEAT_W'(i)) begin
                                        slots_d[32*i +: 32] = cbus_wrdata;
                                    end
                                end
                                wr_exp_d = req_beat + BEAT_W'(1);
                            end
                        end
                    end else if (!beat_ok) begin
                        cbus_rresp = 1'b1;
                    end else if (rd_hit) begin
                        cbus_rresp  = 1'b1;
                        cbus_rddata = beat_data;
                    end else begin
                        addr_d  = req_line;
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                mem_req = 1'b1;
                if (mem_waccept) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                mem_req = 1'b1;
                mem_cmd = 1'b1;
                if (mem_rresp) begin
                    state_d = RD_CAPT;
                end
            end
            RD_CAPT: begin
                line_buf_d  = mem_rd_data;
                tag_d       = addr_q;
                tag_valid_d = 1'b1;
                fresh_d     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // live_q holds CBUS handshakes off for the first cycle after reset
    always_ff @(posedge clk) begin
        if (!sreset_n) begin
            state_q     <= IDLE;
            slots_q     <= '0;
            line_buf_q  <= '0;
            addr_q      <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            wr_exp_q    <= '0;
            seq_err_q   <= 1'b0;
            fresh_q     <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slots_q     <= slots_d;
            line_buf_q  <= line_buf_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            wr_exp_q    <= wr_exp_d;
            seq_err_q   <= seq_err_d;
            fresh_q     <= fresh_d;
            live_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cbus_width_converter_n.sv
// Directed bench for cbus_width_converter_n: a DW=96 instance driven through a CBUS task with a
// delayed memory responder, plus a DW=80 instance for the partial top beat.
module tb_cbus_width_converter_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sreset_n;
    logic        cbus_req, cbus_cmd;
    logic [33:0] cbus_addr;
    logic [31:0] cbus_wrdata, cbus_rddata;
    logic        cbus_waccept, cbus_rresp;
    logic        mem_req, mem_cmd;
    logic [31:0] mem_addr;
    logic [95:0] mem_wrdata, mem_rd_data;
    logic        mem_waccept, mem_rresp, wr_seq_err;

    logic        b_cbus_req, b_cbus_cmd;
    logic [33:0] b_cbus_addr;
    logic [31:0] b_cbus_wrdata, b_cbus_rddata;
    logic        b_cbus_waccept, b_cbus_rresp;
    logic        b_mem_req, b_mem_cmd;
    logic [31:0] b_mem_addr;
    logic [79:0] b_mem_wrdata, b_mem_rd_data;
    logic        b_mem_waccept, b_mem_rresp, b_wr_seq_err;

    cbus_width_converter_n #(.DW(96), .AW(32), .BEATS(3), .BEAT_W(2)) dut (
        .clk(clk), .sreset_n(sreset_n),
        .cbus_req(cbus_req), .cbus_cmd(cbus_cmd), .cbus_addr(cbus_addr),
        .cbus_wrdata(cbus_wrdata), .cbus_rddata(cbus_rddata),
        .cbus_waccept(cbus_waccept), .cbus_rresp(cbus_rresp),
        .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_wrdata(mem_wrdata), .mem_rd_data(mem_rd_data),
        .mem_waccept(mem_waccept), .mem_rresp(mem_rresp), .wr_seq_err(wr_seq_err)
    );

    cbus_width_converter_n #(.DW(80), .AW(32), .BEATS(3), .BEAT_W(2)) dut_b (
        .clk(clk), .sreset_n(sreset_n),
        .cbus_req(b_cbus_req), .cbus_cmd(b_cbus_cmd), .cbus_addr(b_cbus_addr),
        .cbus_wrdata(b_cbus_wrdata), .cbus_rddata(b_cbus_rddata),
        .cbus_waccept(b_cbus_waccept), .cbus_rresp(b_cbus_rresp),
        .mem_req(b_mem_req), .mem_cmd(b_mem_cmd), .mem_addr(b_mem_addr),
        .mem_wrdata(b_mem_wrdata), .mem_rd_data(b_mem_rd_data),
        .mem_waccept(b_mem_waccept), .mem_rresp(b_mem_rresp), .wr_seq_err(b_wr_seq_err)
    );

    int check_count = 0;
    int fail_count  = 0;

    int          resp_delay = 1;
    int          mem_count  = 0;
    int          wait_cnt   = 0;
    int          req_cycles = 0;
    int          seq_err_count = 0;
    logic        last_cmd = 1'b0;
    logic [31:0] last_addr = '0;
    logic [95:0] last_wrdata = '0;
    logic [95:0] rd_line = '0;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One CBUS transaction on the DW=96 instance; cycles counts stall cycles before the handshake
    task automatic applyStimulus(input logic cmd, input logic [31:0] line, input logic [1:0] beat,
                                 input logic [31:0] data, output int cycles, output logic [31:0] rdata);
        bit done;
        done   = 1'b0;
        cycles = 0;
        rdata  = '0;
        @(posedge clk);
        #1;
        cbus_req    = 1'b1;
        cbus_cmd    = cmd;
        cbus_addr   = {line, beat};
        cbus_wrdata = data;
        while (!done && cycles < 50) begin
            @(negedge clk);
            if (cmd ? cbus_rresp : cbus_waccept) begin
                done  = 1'b1;
                rdata = cbus_rddata;
            end else begin
                cycles++;
            end
            @(posedge clk);
            #1;
        end
        cbus_req = 1'b0;
        checkOutput("handshake_timeout", 128'(done), 128'd1);
    endtask

    // Memory responder: answers mem_req after resp_delay cycles and records the transaction
    initial begin
        mem_waccept = 1'b0;
        mem_rresp   = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            mem_waccept = 1'b0;
            mem_rresp   = 1'b0;
            if (sreset_n && mem_req) begin
                wait_cnt++;
                if (wait_cnt >= resp_delay) begin
                    if (mem_cmd) mem_rresp = 1'b1;
                    else         mem_waccept = 1'b1;
                    mem_rd_data = rd_line;
                    mem_count++;
                    last_cmd    = mem_cmd;
                    last_addr   = mem_addr;
                    last_wrdata = mem_wrdata;
                    req_cycles  = wait_cnt;
                    wait_cnt    = 0;
                end
            end else begin
                wait_cnt = 0;
            end
            if (wr_seq_err) seq_err_count++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          c0, c1, c2, n;
        int          exp_mem;
        logic [31:0] d0, d1, d2;

        sreset_n    = 1'b0;
        cbus_req    = 1'b1;
        cbus_cmd    = 1'b0;
        cbus_addr   = {32'h40, 2'd0};
        cbus_wrdata = 32'hDEADBEEF;
        b_cbus_req = 1'b0; b_cbus_cmd = 1'b0; b_cbus_addr = '0; b_cbus_wrdata = '0;
        b_mem_rd_data = '0; b_mem_waccept = 1'b0; b_mem_rresp = 1'b0;

        idle(2);
        @(negedge clk);
        checkOutput("reset_outputs",
                    {cbus_waccept, cbus_rresp, mem_req, mem_cmd, wr_seq_err,
                     |cbus_rddata, |mem_addr, |mem_wrdata}, 8'h00);
        @(posedge clk);
        #1;
        cbus_req = 1'b0;
        sreset_n = 1'b1;
        idle(2);

        // Full line write with a slow memory accept
        resp_delay = 3;
        applyStimulus(1'b0, 32'h40, 2'd0, 32'h11111111, c0, d0);
        applyStimulus(1'b0, 32'h40, 2'd1, 32'h22222222, c1, d0);
        applyStimulus(1'b0, 32'h40, 2'd2, 32'h33333333, c2, d0);
        idle(6);
        checkOutput("wr_accept_stalls", 128'(c0 + c1 + c2), 128'd0);
        checkOutput("wr_mem_count", 128'(mem_count), 128'd1);
        checkOutput("wr_mem_cmd", 128'(last_cmd), 128'd0);
        checkOutput("wr_mem_addr", 128'(last_addr), 128'h40);
        checkOutput("wr_mem_data", 128'(last_wrdata), 128'h333333332222222211111111);
        checkOutput("wr_req_hold", 128'(req_cycles), 128'd3);
        checkOutput("wr_no_seq_err", 128'(seq_err_count), 128'd0);
        exp_mem = 1;

        // Read line: beat 0 misses, beats 1 and 2 hit in zero cycles
        resp_delay = 1;
        rd_line    = 96'hAAAABBBB_CCCCDDDD_EEEEFFFF;
        applyStimulus(1'b1, 32'h40, 2'd0, '0, c0, d0);
        applyStimulus(1'b1, 32'h40, 2'd1, '0, c1, d1);
        applyStimulus(1'b1, 32'h40, 2'd2, '0, c2, d2);
        exp_mem++;
        checkOutput("rd_miss_latency", 128'(c0), 128'd3);
        checkOutput("rd_beat0", 128'(d0), 128'hEEEEFFFF);
        checkOutput("rd_beat1_lat", 128'(c1), 128'd0);
        checkOutput("rd_beat1", 128'(d1), 128'hCCCCDDDD);
        checkOutput("rd_beat2_lat", 128'(c2), 128'd0);
        checkOutput("rd_beat2", 128'(d2), 128'hAAAABBBB);
        checkOutput("rd_mem_count", 128'(mem_count), 128'(exp_mem));
        checkOutput("rd_mem_cmd", 128'(last_cmd), 128'd1);
        checkOutput("rd_mem_addr", 128'(last_addr), 128'h40);

        // Re-read of beat 0 on the cached line
        applyStimulus(1'b1, 32'h40, 2'd0, '0, c0, d0);
`ifdef CBUS_WC_RD_CACHE_EN
        checkOutput("rd_beat0_again_lat", 128'(c0), 128'd0);
`else
        exp_mem++;
        checkOutput("rd_beat0_again_lat", 128'(c0), 128'd3);
`endif
        checkOutput("rd_beat0_again", 128'(d0), 128'hEEEEFFFF);
        checkOutput("rd_beat0_again_count", 128'(mem_count), 128'(exp_mem));

        // Out-of-order write: beat 0 then beat 2 keeps the stale slot 1
        applyStimulus(1'b0, 32'h50, 2'd0, 32'h55555555, c0, d0);
        applyStimulus(1'b0, 32'h50, 2'd2, 32'h77777777, c2, d0);
        idle(4);
        exp_mem++;
        checkOutput("seq_err_pulses", 128'(seq_err_count), 128'd1);
        checkOutput("seq_wr_data", 128'(last_wrdata), 128'h777777772222222255555555);
        checkOutput("seq_wr_addr", 128'(last_addr), 128'h50);
        checkOutput("seq_mem_count", 128'(mem_count), 128'(exp_mem));

        // Writing the cached line invalidates the tag
        applyStimulus(1'b0, 32'h40, 2'd0, 32'h00000001, c0, d0);
        applyStimulus(1'b0, 32'h40, 2'd1, 32'h00000002, c0, d0);
        applyStimulus(1'b0, 32'h40, 2'd2, 32'h00000003, c0, d0);
        idle(3);
        exp_mem++;
        checkOutput("inv_wr_data", 128'(last_wrdata), 128'h000000030000000200000001);
        applyStimulus(1'b1, 32'h40, 2'd1, '0, c1, d1);
        exp_mem++;
        checkOutput("inv_rd_latency", 128'(c1), 128'd3);
        checkOutput("inv_rd_data", 128'(d1), 128'hCCCCDDDD);
        checkOutput("inv_mem_count", 128'(mem_count), 128'(exp_mem));

        // Beat index 3 is out of range on a 3-beat line
        applyStimulus(1'b1, 32'h40, 2'd3, '0, c0, d0);
        checkOutput("oor_rd_latency", 128'(c0), 128'd0);
        checkOutput("oor_rd_data", 128'(d0), 128'd0);
        applyStimulus(1'b0, 32'h40, 2'd3, 32'h99999999, c1, d0);
        idle(3);
        checkOutput("oor_wr_latency", 128'(c1), 128'd0);
        checkOutput("oor_wr_seq_err", 128'(seq_err_count), 128'd2);
        checkOutput("oor_mem_count", 128'(mem_count), 128'(exp_mem));

        // A read between partial write beats leaves the write sequence intact
        applyStimulus(1'b0, 32'h60, 2'd0, 32'hA0A0A0A0, c0, d0);
        applyStimulus(1'b1, 32'h40, 2'd2, '0, c1, d2);
        applyStimulus(1'b0, 32'h60, 2'd1, 32'hA1A1A1A1, c0, d0);
        applyStimulus(1'b0, 32'h60, 2'd2, 32'hA2A2A2A2, c0, d0);
        idle(3);
        exp_mem++;
        checkOutput("mix_rd_latency", 128'(c1), 128'd0);
        checkOutput("mix_rd_data", 128'(d2), 128'hAAAABBBB);
        checkOutput("mix_seq_err", 128'(seq_err_count), 128'd2);
        checkOutput("mix_wr_data", 128'(last_wrdata), 128'hA2A2A2A2A1A1A1A1A0A0A0A0);
        checkOutput("mix_wr_addr", 128'(last_addr), 128'h60);

        // Reset while a read is outstanding abandons it and drops the cached tag
        resp_delay = 10;
        @(posedge clk);
        #1;
        cbus_req  = 1'b1;
        cbus_cmd  = 1'b1;
        cbus_addr = {32'h70, 2'd1};
        idle(3);
        @(negedge clk);
        checkOutput("rst_mem_req_before", 128'(mem_req), 128'd1);
        @(posedge clk);
        #1;
        sreset_n = 1'b0;
        cbus_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req_after", 128'(mem_req), 128'd0);
        @(posedge clk);
        #1;
        sreset_n   = 1'b1;
        resp_delay = 1;
        idle(1);
        checkOutput("rst_abandon_count", 128'(mem_count), 128'(exp_mem));
        applyStimulus(1'b1, 32'h40, 2'd1, '0, c1, d1);
        exp_mem++;
        checkOutput("rst_rd_latency", 128'(c1), 128'd3);
        checkOutput("rst_rd_data", 128'(d1), 128'hCCCCDDDD);
        checkOutput("rst_mem_count", 128'(mem_count), 128'(exp_mem));

        // DW=80: top beat carries only 16 bits, zero-extended
        @(posedge clk);
        #1;
        b_cbus_req  = 1'b1;
        b_cbus_cmd  = 1'b1;
        b_cbus_addr = {32'h10, 2'd2};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_mem_req && n < 20);
        checkOutput("b_mem_req", 128'(b_mem_req), 128'd1);
        checkOutput("b_mem_addr", 128'(b_mem_addr), 128'h10);
        b_mem_rresp   = 1'b1;
        b_mem_rd_data = 80'h1234_5678_9ABC_DEF0_4321;
        @(negedge clk);
        b_mem_rresp = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_cbus_rresp && n < 20);
        checkOutput("b_beat2_rresp", 128'(b_cbus_rresp), 128'd1);
        checkOutput("b_beat2_data", 128'(b_cbus_rddata), 128'h00001234);
        @(posedge clk);
        #1;
        b_cbus_addr = {32'h10, 2'd1};
        @(negedge clk);
        checkOutput("b_beat1_rresp", 128'(b_cbus_rresp), 128'd1);
        checkOutput("b_beat1_data", 128'(b_cbus_rddata), 128'h56789ABC);
        @(posedge clk);
        #1;
        b_cbus_req = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
